pixel_pair_write_scheduler: RTL and testbench
=============================================

PIXEL_PAIR_WRITE_SCHEDULER -- requirements
Module: pixel_pair_write_scheduler

Interface
REQ-001 clk  in  1  sole clock; all state on rising edge.
REQ-002 rst  in  1  reset, asynchronous, active-high.
REQ-003 i_noblend  in  1  blending disabled; sampled at pair accept.
REQ-004 i_checkMask  in  1  skip destination pixels whose VRAM bit15=1; sampled at pair accept.
REQ-005 i_cntClr  in  1  synchronous clear of o_skipCount.
REQ-006 i_pxValid  in  1  pixel pair offered.
REQ-007 o_pxReady  out  1  pair accepted when i_pxValid&o_pxReady.
REQ-008 i_pxAdr  in  18  VRAM 32-bit word address of pair ({y[8:0],x[9:1]}).
REQ-009 i_pxSel  in  2  bit0=left pixel written, bit1=right pixel written.
REQ-010 o_stageLoad  out  1  load strobe for the shading/blend/dither input registers (=accept).
REQ-011 o_bgLoad  out  1  load strobe for the background registers (rBG/gBG/bBG L/R).
REQ-012 i_write32  in  32  final pixel pair from the combinational compute datapath.
REQ-013 o_memReq  out  1  memory request.
REQ-014 o_memWrite  out  1  1=write, 0=read; valid with o_memReq.
REQ-015 o_memAdr  out  18  word address; valid with o_memReq.
REQ-016 o_memSel  out  2  halfword enables (bit0=[15:0], bit1=[31:16]).
REQ-017 o_memWrData  out  32  write data.
REQ-018 i_memAck  in  1  request taken this cycle.
REQ-019 i_memRdValid  in  1  read data valid.
REQ-020 i_memRdData  in  32  read data.
REQ-021 o_busy  out  1  state != IDLE.
REQ-022 o_skipCount  out  16  pairs fully dropped by mask check, saturating.

Function
REQ-023 States IDLE, RD_REQ, RD_WAIT, WR_REQ; one pair in flight.
REQ-024 o_pxReady = !rst & (IDLE | (WR_REQ & i_memAck)); o_stageLoad = i_pxValid & o_pxReady.
REQ-025 On accept: latch adr, sel, chk=i_checkMask, needBG = i_checkMask | !i_noblend.
REQ-026 Accept with i_pxSel=00: no memory access, next state IDLE.
REQ-027 Accept with sel!=0: next RD_REQ if needBG, else WR_REQ.
REQ-028 RD_REQ: o_memReq=1, o_memWrite=0, o_memSel=11, latched adr; held stable until i_memAck, then RD_WAIT.
REQ-029 RD_WAIT: wait any number of cycles; on i_memRdValid assert o_bgLoad combinationally same cycle.
REQ-030 Effective sel at read return: sel & ~(chk ? {rd[31],rd[15]} : 00).
REQ-031 Effective sel=00: go IDLE, increment o_skipCount (saturate at FFFF); else latch effective sel, go WR_REQ.
REQ-032 WR_REQ: o_memReq=1, o_memWrite=1, o_memSel=effective sel, o_memWrData=i_write32 (pass-through); held until i_memAck.
REQ-033 WR_REQ + i_memAck: if new pair accepted same cycle apply REQ-025..027 transitions, else IDLE (zero bubble back-to-back).
REQ-034 i_memRdValid outside RD_WAIT ignored; i_memAck outside RD_REQ/WR_REQ ignored.
REQ-035 o_memReq=0 in IDLE and RD_WAIT; o_memAdr/o_memSel/o_memWrData don't-care when o_memReq=0 but driven 0 in IDLE.
REQ-036 i_cntClr has priority over simultaneous increment (result 0).
REQ-037 Config input changes after accept do not affect the in-flight pair.

Reset
REQ-038 rst high: state IDLE, latched adr/sel/chk/needBG=0, o_skipCount=0, o_memReq=0, o_bgLoad=0, o_stageLoad=0, o_pxReady=0, o_busy=0.
REQ-039 rst asserted mid-request abandons the transaction immediately; no request reissued after release; o_pxReady=1 first cycle after release.

Verification
REQ-040 noblend=1, checkMask=0, pair adr=0x00123 sel=11 -> stageLoad 1 cycle, next cycle write req adr 0x00123 sel=11 data=i_write32; no read issued.
REQ-041 noblend=0, checkMask=1, sel=11, read returns 0x8000_0000 after 3 wait cycles -> bgLoad on return cycle, write sel=01; skipCount unchanged.
REQ-042 checkMask=1, read returns 0x8000_8000 -> no write, IDLE, skipCount 0->1; repeat with cntClr same cycle -> skipCount 0.
REQ-043 Two pairs streamed, noblend=1, ack every cycle -> second accept coincides with first write ack; writes on consecutive cycles.
REQ-044 rst pulsed while in RD_WAIT, then late i_memRdValid -> ignored, no bgLoad, no write, o_busy=0.
REQ-045 skipCount preset to FFFF via 65535 dropped pairs, one more drop -> stays FFFF.

Source files
------------

// File: rtl/pixel_pair_write_scheduler.sv
// pixel_pair_write_scheduler: sequences the optional background read and the
// masked write of one VRAM pixel pair at a time.
module pixel_pair_write_scheduler (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_noblend,
    input  logic        i_checkMask,
    input  logic        i_cntClr,
    input  logic        i_pxValid,
    output logic        o_pxReady,
    input  logic [17:0] i_pxAdr,
    input  logic [1:0]  i_pxSel,
    output logic        o_stageLoad,
    output logic        o_bgLoad,
    input  logic [31:0] i_write32,
    output logic        o_memReq,
    output logic        o_memWrite,
    output logic [17:0] o_memAdr,
    output logic [1:0]  o_memSel,
    output logic [31:0] o_memWrData,
    input  logic        i_memAck,
    input  logic        i_memRdValid,
    input  logic [31:0] i_memRdData,
    output logic        o_busy,
    output logic [15:0] o_skipCount
);

    typedef enum logic [1:0] {
        IDLE,
        RD_REQ,
        RD_WAIT,
        WR_REQ
    } state_t;

    state_t      state;
    state_t      acceptNext;
    logic [17:0] adrQ;
    logic [1:0]  selQ;
    logic        chkQ;
    logic        needBgQ;
    logic [15:0] skipCnt;
    logic        accept;
    logic        rdReturn;
    logic [1:0]  maskBits;
    logic [1:0]  effSel;
    logic        unusedRdBits;

    assign unusedRdBits = ^{i_memRdData[30:16], i_memRdData[14:0]};

    assign o_pxReady   = !rst && ((state == IDLE) ||
                                  ((state == WR_REQ) && i_memAck));
    assign accept      = i_pxValid && o_pxReady;
    assign o_stageLoad = accept;

    assign rdReturn = (state == RD_WAIT) && needBgQ && i_memRdValid;
    assign o_bgLoad = rdReturn;

    // Destination pixels with bit15 set are protected when masking is on
    assign maskBits = chkQ ? {i_memRdData[31], i_memRdData[15]} : 2'b00;
    assign effSel   = selQ & ~maskBits;

    assign acceptNext = (i_pxSel == 2'b00) ? IDLE :
                        (i_checkMask || !i_noblend) ? RD_REQ : WR_REQ;

    assign o_memReq    = (state == RD_REQ) || (state == WR_REQ);
    assign o_memWrite  = (state == WR_REQ);
    assign o_memAdr    = o_memReq ? adrQ : 18'd0;
    assign o_memSel    = (state == RD_REQ) ? 2'b11 :
                         (state == WR_REQ) ? selQ : 2'b00;
    assign o_memWrData = (state == WR_REQ) ? i_write32 : 32'd0;
    assign o_busy      = (state != IDLE);
    assign o_skipCount = skipCnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            adrQ    <= 18'd0;
            selQ    <= 2'b00;
            chkQ    <= 1'b0;
            needBgQ <= 1'b0;
            skipCnt <= 16'd0;
        end else begin
            if (accept) begin
                adrQ    <= i_pxAdr;
                selQ    <= i_pxSel;
                chkQ    <= i_checkMask;
                needBgQ <= i_checkMask || !i_noblend;
            end
            unique case (state)
                IDLE: begin
                    if (accept) state <= acceptNext;
                end
                RD_REQ: begin
                    if (i_memAck) state <= RD_WAIT;
                end
                RD_WAIT: begin
                    if (rdReturn) begin
                        if (effSel == 2'b00) begin
                            state <= IDLE;
                        end else begin
                            selQ  <= effSel;
                            state <= WR_REQ;
                        end
                    end
                end
                WR_REQ: begin
                    // Back-to-back pairs enter directly with no idle bubble
                    if (i_memAck) state <= accept ? acceptNext : IDLE;
                end
                default: state <= IDLE;
            endcase
            if (i_cntClr) begin
                skipCnt <= 16'd0;
            end else if (rdReturn && (effSel == 2'b00) &&
                         (skipCnt != 16'hFFFF)) begin
                skipCnt <= skipCnt + 16'd1;
            end
        end
    end

endmodule

// File: tb/tb_pixel_pair_write_scheduler.sv
// Bench for pixel_pair_write_scheduler: pair-level reference model checked
// every cycle, plus directed scenarios with literal expectations.
module tb_pixel_pair_write_scheduler;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        i_noblend = 1'b0;
    logic        i_checkMask = 1'b0;
    logic        i_cntClr = 1'b0;
    logic        i_pxValid = 1'b0;
    logic        o_pxReady;
    logic [17:0] i_pxAdr = 18'd0;
    logic [1:0]  i_pxSel = 2'b00;
    logic        o_stageLoad;
    logic        o_bgLoad;
    logic [31:0] i_write32 = 32'd0;
    logic        o_memReq;
    logic        o_memWrite;
    logic [17:0] o_memAdr;
    logic [1:0]  o_memSel;
    logic [31:0] o_memWrData;
    logic        i_memAck = 1'b0;
    logic        i_memRdValid = 1'b0;
    logic [31:0] i_memRdData = 32'd0;
    logic        o_busy;
    logic [15:0] o_skipCount;

    pixel_pair_write_scheduler dut (
        .clk(clk), .rst(rst),
        .i_noblend(i_noblend), .i_checkMask(i_checkMask),
        .i_cntClr(i_cntClr), .i_pxValid(i_pxValid),
        .o_pxReady(o_pxReady), .i_pxAdr(i_pxAdr), .i_pxSel(i_pxSel),
        .o_stageLoad(o_stageLoad), .o_bgLoad(o_bgLoad),
        .i_write32(i_write32), .o_memReq(o_memReq),
        .o_memWrite(o_memWrite), .o_memAdr(o_memAdr),
        .o_memSel(o_memSel), .o_memWrData(o_memWrData),
        .i_memAck(i_memAck), .i_memRdValid(i_memRdValid),
        .i_memRdData(i_memRdData), .o_busy(o_busy),
        .o_skipCount(o_skipCount)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h (cycle %0d)",
                     nm, act, exp, cyc);
        end
    endtask

    // Pair-level model: one pending pair with read/return progress flags
    bit          mPend = 0;
    logic [17:0] mAdr = 0;
    logic [1:0]  mSel = 0;
    bit          mChk = 0;
    bit          mNeedBg = 0;
    bit          mRdAck = 0;
    bit          mRdDone = 0;
    logic [15:0] mSkip = 0;

    function automatic bit fRd();
        return mPend && mNeedBg && !mRdAck;
    endfunction
    function automatic bit fWait();
        return mPend && mNeedBg && mRdAck && !mRdDone;
    endfunction
    function automatic bit fWr();
        return mPend && (!mNeedBg || mRdDone);
    endfunction

    always @(posedge clk or posedge rst) begin
        bit wr, rd, wt, acc;
        logic [1:0] eff;
        if (rst) begin
            mPend = 0; mAdr = 0; mSel = 0; mChk = 0;
            mNeedBg = 0; mRdAck = 0; mRdDone = 0; mSkip = 0;
        end else begin
            wr  = fWr();
            rd  = fRd();
            wt  = fWait();
            acc = i_pxValid && (!mPend || (wr && i_memAck));
            if (wr && i_memAck) mPend = 0;
            if (rd && i_memAck) mRdAck = 1;
            if (wt && i_memRdValid) begin
                eff = mSel;
                if (mChk && i_memRdData[15]) eff[0] = 1'b0;
                if (mChk && i_memRdData[31]) eff[1] = 1'b0;
                if (eff == 2'b00) begin
                    mPend = 0;
                    if (mSkip != 16'hFFFF) mSkip = mSkip + 1;
                end else begin
                    mSel = eff;
                    mRdDone = 1;
                end
            end
            if (i_cntClr) mSkip = 0;
            if (acc) begin
                mPend   = (i_pxSel != 2'b00);
                mAdr    = i_pxAdr;
                mSel    = i_pxSel;
                mChk    = i_checkMask;
                mNeedBg = i_checkMask || !i_noblend;
                mRdAck  = 0;
                mRdDone = 0;
            end
        end
    end

    int          accCyc[$];
    int          wrCyc[$];
    int          rdCyc[$];
    int          bgCyc[$];
    int          rvCyc[$];
    logic [17:0] wrAdr[$];
    logic [1:0]  wrSel[$];
    logic [31:0] wrData[$];

    always @(posedge clk) begin
        bit eRd, eWr, eWt, eRdy;
        cyc++;
        #4;
        eRd  = fRd();
        eWr  = fWr();
        eWt  = fWait();
        eRdy = !rst && (!mPend || (eWr && i_memAck));
        chk("pxReady", 32'(o_pxReady), 32'(eRdy));
        chk("stageLoad", 32'(o_stageLoad), 32'(i_pxValid && eRdy));
        chk("memReq", 32'(o_memReq), 32'(eRd || eWr));
        chk("busy", 32'(o_busy), 32'(mPend));
        chk("bgLoad", 32'(o_bgLoad), 32'(eWt && i_memRdValid));
        chk("skipCount", 32'(o_skipCount), 32'(mSkip));
        if (eRd || eWr) begin
            chk("memWrite", 32'(o_memWrite), 32'(eWr));
            chk("memAdr", 32'(o_memAdr), 32'(mAdr));
            chk("memSel", 32'(o_memSel), eRd ? 32'd3 : 32'(mSel));
        end else if (!mPend) begin
            chk("idleAdr", 32'(o_memAdr), 32'd0);
            chk("idleSel", 32'(o_memSel), 32'd0);
            chk("idleData", o_memWrData, 32'd0);
        end
        if (eWr) chk("memWrData", o_memWrData, i_write32);
        if (o_stageLoad) accCyc.push_back(cyc);
        if (o_memReq && i_memAck && o_memWrite) begin
            wrCyc.push_back(cyc);
            wrAdr.push_back(o_memAdr);
            wrSel.push_back(o_memSel);
            wrData.push_back(o_memWrData);
        end
        if (o_memReq && i_memAck && !o_memWrite) rdCyc.push_back(cyc);
        if (o_bgLoad) bgCyc.push_back(cyc);
        if (i_memRdValid) rvCyc.push_back(cyc);
    end

    // Memory responder: ack after ackDelay cycles, read data rdLatency later
    int          ackDelay = 0;
    int          rdLatency = 0;
    logic [31:0] rdData = 32'd0;
    bit          rdPend = 0;
    int          rdWait = 0;
    int          reqAge = 0;

    always @(posedge clk) begin
        #2;
        i_memRdValid = 1'b0;
        if (rdPend) begin
            if (rdWait == 0) begin
                i_memRdValid = 1'b1;
                i_memRdData = rdData;
                rdPend = 0;
            end else begin
                rdWait--;
            end
        end
        if (o_memReq) begin
            i_memAck = (reqAge >= ackDelay);
            reqAge = i_memAck ? 0 : reqAge + 1;
        end else begin
            i_memAck = 1'b0;
            reqAge = 0;
        end
        if (i_memAck && !o_memWrite) begin
            rdPend = 1;
            rdWait = rdLatency;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic sendPair(input logic [17:0] adr, input logic [1:0] sel,
                            input bit nb, input bit cm);
        i_pxValid = 1'b1;
        i_pxAdr = adr;
        i_pxSel = sel;
        i_noblend = nb;
        i_checkMask = cm;
        for (int n = 0; n < 60; n++) begin
            #2;
            if (o_stageLoad) begin
                step();
                // Scramble config so in-flight behaviour must not follow it
                i_pxValid = 1'b0;
                i_pxAdr = ~adr;
                i_pxSel = ~sel;
                i_noblend = !nb;
                i_checkMask = !cm;
                return;
            end
            step();
        end
        i_pxValid = 1'b0;
        chk("acceptTimeout", 32'd0, 32'd1);
    endtask

    task automatic waitIdle(input bit clrOnReturn);
        for (int n = 0; n < 200; n++) begin
            #2;
            if (!o_busy) begin
                step();
                return;
            end
            if (clrOnReturn && o_bgLoad) i_cntClr = 1'b1;
            step();
            i_cntClr = 1'b0;
        end
        chk("idleTimeout", 32'd0, 32'd1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int nw, nr, na, nb, nv;
        i_write32 = 32'hA5A5_5A5A;
        repeat (3) @(posedge clk);
        #4;
        chk("rst_pxReady", 32'(o_pxReady), 32'd0);
        chk("rst_busy", 32'(o_busy), 32'd0);
        chk("rst_memReq", 32'(o_memReq), 32'd0);
        chk("rst_skip", 32'(o_skipCount), 32'd0);
        @(posedge clk);
        #1 rst = 1'b0;
        #3 chk("rel_pxReady", 32'(o_pxReady), 32'd1);
        step();

        // Plain write, no background read
        nw = wrCyc.size(); nr = rdCyc.size(); na = accCyc.size();
        sendPair(18'h00123, 2'b11, 1, 0);
        waitIdle(0);
        chk("t1_wrCount", wrCyc.size() - nw, 1);
        chk("t1_rdCount", rdCyc.size() - nr, 0);
        chk("t1_adr", 32'(wrAdr[nw]), 32'h00123);
        chk("t1_sel", 32'(wrSel[nw]), 32'd3);
        chk("t1_data", wrData[nw], 32'hA5A5_5A5A);
        chk("t1_latency", wrCyc[nw] - accCyc[na], 1);

        // Masked right pixel after a 3-cycle read wait
        rdLatency = 3;
        rdData = 32'h8000_0000;
        i_write32 = 32'h1234_5678;
        nw = wrCyc.size(); nr = rdCyc.size(); nb = bgCyc.size();
        sendPair(18'h2ABCD, 2'b11, 0, 1);
        waitIdle(0);
        chk("t2_wrCount", wrCyc.size() - nw, 1);
        chk("t2_sel", 32'(wrSel[nw]), 32'd1);
        chk("t2_data", wrData[nw], 32'h1234_5678);
        chk("t2_bgCount", bgCyc.size() - nb, 1);
        chk("t2_bgCycle", bgCyc[nb] - rdCyc[nr], 4);
        chk("t2_skip", 32'(o_skipCount), 32'd0);

        // Fully masked pair is dropped, then a drop with a coincident clear
        rdData = 32'h8000_8000;
        nw = wrCyc.size();
        sendPair(18'h00042, 2'b11, 1, 1);
        waitIdle(0);
        chk("t3_wrCount", wrCyc.size() - nw, 0);
        chk("t3_skip", 32'(o_skipCount), 32'd1);
        sendPair(18'h00043, 2'b11, 1, 1);
        waitIdle(1);
        chk("t3_wrCount2", wrCyc.size() - nw, 0);
        chk("t3_skipClr", 32'(o_skipCount), 32'd0);

        // Empty select: accepted, no memory traffic
        nw = wrCyc.size(); nr = rdCyc.size(); na = accCyc.size();
        sendPair(18'h00777, 2'b00, 0, 1);
        waitIdle(0);
        chk("t4_accCount", accCyc.size() - na, 1);
        chk("t4_memCount", (wrCyc.size() - nw) + (rdCyc.size() - nr), 0);

        // Two streamed pairs with zero bubble
        i_write32 = 32'hCAFE_F00D;
        nw = wrCyc.size(); na = accCyc.size();
        sendPair(18'h3FFFF, 2'b10, 1, 0);
        sendPair(18'h00001, 2'b01, 1, 0);
        waitIdle(0);
        chk("t5_wrCount", wrCyc.size() - nw, 2);
        chk("t5_overlap", accCyc[na + 1] - wrCyc[nw], 0);
        chk("t5_consec", wrCyc[nw + 1] - wrCyc[nw], 1);
        chk("t5_adr0", 32'(wrAdr[nw]), 32'h3FFFF);
        chk("t5_adr1", 32'(wrAdr[nw + 1]), 32'h00001);
        chk("t5_sel1", 32'(wrSel[nw + 1]), 32'd1);

        // Slow acks: requests must hold until taken
        ackDelay = 2;
        rdLatency = 1;
        rdData = 32'hFFFF_FFFF;
        nw = wrCyc.size(); na = accCyc.size();
        sendPair(18'h15555, 2'b11, 0, 0);
        waitIdle(0);
        chk("t6_sel", 32'(wrSel[nw]), 32'd3);
        chk("t6_latency", wrCyc[nw] - accCyc[na], 8);

        // Reset during read wait; late read data is ignored
        ackDelay = 0;
        rdLatency = 6;
        nw = wrCyc.size(); nb = bgCyc.size(); nv = rvCyc.size();
        sendPair(18'h01010, 2'b11, 0, 0);
        step();
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        repeat (10) step();
        chk("t7_rdValidSeen", rvCyc.size() - nv, 1);
        chk("t7_bgCount", bgCyc.size() - nb, 0);
        chk("t7_wrCount", wrCyc.size() - nw, 0);
        chk("t7_busy", 32'(o_busy), 32'd0);

        // Saturation near the top of the counter
        force dut.skipCnt = 16'hFFFD;
        mSkip = 16'hFFFD;
        #1 release dut.skipCnt;
        step();
        rdLatency = 0;
        rdData = 32'h8000_8000;
        sendPair(18'h00100, 2'b11, 1, 1);
        waitIdle(0);
        chk("t8_skipFFFE", 32'(o_skipCount), 32'h0000FFFE);
        sendPair(18'h00101, 2'b01, 1, 1);
        waitIdle(0);
        chk("t8_skipFFFF", 32'(o_skipCount), 32'h0000FFFF);
        sendPair(18'h00102, 2'b10, 1, 1);
        waitIdle(0);
        chk("t8_skipSat", 32'(o_skipCount), 32'h0000FFFF);

        repeat (3) step();
        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
